writeback_arbiter: RTL and testbench
====================================

Name: writeback_arbiter

Overview:
Sole driver of the register file's single write port and its predicate write port. Merges two result producers into one register write per cycle: the ALU, which has priority, and the load/store unit's load responses, which are buffered. Load responses go through a small FIFO, and a starvation counter guarantees they drain. Sits between the execute/memory stages and the register file. Also exports per-thread pending-write flags so the warp scheduler can hold dependent issue.

Parameters:
DATA_W, 18, register data width
FIFO_DEPTH, 4, load-response buffer entries (power of two, >=2)
STARVE_LIMIT, 3, consecutive ALU grants with FIFO non-empty before a load is forced

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
alu_valid  in  1  ALU result present
alu_ready  out  1  ALU result accepted this cycle
alu_thread  in  4  destination thread
alu_rd  in  4  destination register
alu_data  in  DATA_W  result
alu_wr_en  in  1  result targets a GPR
alu_pred_en  in  1  result also writes the thread predicate
alu_pred  in  1  predicate value
mem_valid  in  1  load response present
mem_ready  out  1  FIFO not full
mem_thread  in  4  destination thread
mem_rd  in  4  destination register
mem_data  in  DATA_W  load data
write_thread  out  4  to register file
write_rd  out  4  to register file
write_data  out  DATA_W  to register file
write_en  out  1  to register file
predicate_write_en  out  1  to register file
predicate_in  out  1  to register file
wb_pending  out  16  bit t set if a write for thread t is in the FIFO or output stage

Behaviour:
- Interface decision: one clock, clk. Reset rst is synchronous and active-high.
- Handshakes are valid/ready. A transfer occurs on valid && ready. A producer must hold its payload stable while valid && !ready.
- mem_ready = FIFO not full. A push on a full FIFO cannot occur.
- Per-cycle arbitration among the ALU and the FIFO head:
  - The load is forced when the FIFO is non-empty and either count >= FIFO_DEPTH-1 or starve_cnt == STARVE_LIMIT.
  - alu_ready = !forced (combinational). When forced, the FIFO head pops.
  - When not forced and alu_valid=0 and the FIFO is non-empty, the FIFO head pops.
- starve_cnt rules:
  - Increments (saturating) on each ALU grant while the FIFO is non-empty.
  - Clears on any pop, or when the FIFO is empty.
- Output stage is registered. A transfer accepted in cycle N appears on the write_* outputs in cycle N+1, one cycle only.
- Idle cycle: write_en = predicate_write_en = 0. write_thread, write_rd and write_data hold their last values.
- ALU output encoding: write_en = alu_wr_en && (alu_rd > 3); predicate_write_en = alu_pred_en; predicate_in = alu_pred.
- Load output encoding: write_en = (mem_rd > 3); predicate_write_en = 0.
- Writes to rd 0-3 are consumed but suppressed (write_en = 0); they are not errors.
- Simultaneous FIFO push and pop: push at the tail, pop at the head, count unchanged. A pop on the empty FIFO is impossible because the arbiter checks emptiness. A push into an empty FIFO cannot pop in the same cycle (no bypass), so minimum load latency is 2 cycles.
- wb_pending is combinational: the OR over valid FIFO entries and the output stage (when write_en or predicate_write_en) of the one-hot thread.
- Reset values: write_* = 0, write_en = 0, predicate_write_en = 0, predicate_in = 0, FIFO empty, starve_cnt = 0, wb_pending = 0.
- Reset mid-operation flushes all buffered loads with no writes issued. During rst=1: mem_ready = 0 and alu_ready = 0.

Decomposition:
- Package gpu_pkg holds: DATA_W; typedefs thread_idx_t (4b), reg_idx_t (4b); constant FIRST_GPR = 4; packed struct wb_req_t {thread, rd, data}.
- One sub-module, wb_fifo: synchronous FIFO of wb_req_t with count output and a per-entry valid/thread view for wb_pending. The arbiter and output stage stay in the top module.

Test Plan:
- ALU only: alu_valid with thread 5, rd 7, data 0x2A, wr_en 1 -> next cycle write_thread=5, write_rd=7, write_data=0x2A, write_en=1, alu_ready held 1.
- Load only: push mem thread 2, rd 4, data 0x3FFFF -> write appears 2 cycles after the push with write_en=1 and predicate_write_en=0. wb_pending[2] is high over that interval.
- Continuous alu_valid with one load queued (STARVE_LIMIT=3) -> three ALU writes, then alu_ready=0 for one cycle and the load is written, then the ALU resumes.
- Fill FIFO to 3 of 4 while the ALU streams -> the load is forced immediately. Push 4 entries back-to-back -> mem_ready drops for exactly the cycles count==4.
- ALU rd=2 with wr_en=1 and pred_en=1, pred=1 -> write_en=0, predicate_write_en=1, predicate_in=1. Load with rd=0 -> consumed, no write.
- Assert rst with 3 loads queued -> following cycle: wb_pending=0, write_en=0. After rst is released, no stale writes appear.

Source files
------------

// File: rtl/gpu_pkg.sv
// gpu_pkg: shared widths, index types and the writeback request record.
package gpu_pkg;
   localparam int DATA_W    = 18;
   localparam int FIRST_GPR = 4;
   typedef logic [3:0] thread_idx_t;
   typedef logic [3:0] reg_idx_t;
   typedef struct packed {
      thread_idx_t       thread;
      reg_idx_t          rd;
      logic [DATA_W-1:0] data;
   } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-response buffer with occupancy count and a per-entry
// valid/thread view so the top can build pending-write flags.
module wb_fifo
   import gpu_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push_i,
   input  logic            pop_i,
   input  wb_req_t         din_i,
   output wb_req_t         head_o,
   output logic [AW:0]     count_o,
   output logic [DEPTH-1:0] vld_o,
   output thread_idx_t     thr_o [DEPTH]
);
   wb_req_t          mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      cnt_q;
   logic [DEPTH-1:0] vld_q, vld_d;
   always_comb begin
      vld_d = vld_q;
      if (pop_i) vld_d[rd_q] = 1'b0;
      if (push_i) vld_d[wr_q] = 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
         vld_q <= '0;
      end else begin
         wr_q  <= push_i ? wr_q + AW'(1) : wr_q;
         rd_q  <= pop_i ? rd_q + AW'(1) : rd_q;
         cnt_q <= cnt_q + (AW+1)'(push_i) - (AW+1)'(pop_i);
         vld_q <= vld_d;
      end
   end
   always_ff @(posedge clk)
      if (push_i) mem_q[wr_q] <= din_i;
   for (genvar i = 0; i < DEPTH; i++) begin : g_thr
      assign thr_o[i] = mem_q[i].thread;
   end
   assign head_o  = mem_q[rd_q];
   assign count_o = cnt_q;
   assign vld_o   = vld_q;
endmodule

// File: rtl/writeback_arbiter.sv
// writeback_arbiter: merges ALU results (priority) and buffered load responses
// into the single register-file write port, with starvation-forced loads.
module writeback_arbiter
   import gpu_pkg::*;
#(
   parameter int FIFO_DEPTH   = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  thread_idx_t       alu_thread,
   input  reg_idx_t          alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              alu_wr_en,
   input  logic              alu_pred_en,
   input  logic              alu_pred,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  thread_idx_t       mem_thread,
   input  reg_idx_t          mem_rd,
   input  logic [DATA_W-1:0] mem_data,
   output thread_idx_t       write_thread,
   output reg_idx_t          write_rd,
   output logic [DATA_W-1:0] write_data,
   output logic              write_en,
   output logic              predicate_write_en,
   output logic              predicate_in,
   output logic [15:0]       wb_pending
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);
   wb_req_t                 head, out_q, out_d;
   logic [CW-1:0]           count;
   logic [FIFO_DEPTH-1:0]   fvld;
   thread_idx_t             fthr [FIFO_DEPTH];
   logic [SW-1:0]           starve_q, starve_d;
   logic                    we_q, we_d, pwe_q, pwe_d, pin_q, pin_d;
   logic                    nonempty, forced, push, pop, alu_go;
   assign nonempty  = count != '0;
   assign forced    = nonempty && (count >= CW'(FIFO_DEPTH - 1) || starve_q == SW'(STARVE_LIMIT));
   assign alu_ready = !rst && !forced;
   assign mem_ready = !rst && count != CW'(FIFO_DEPTH);
   assign alu_go    = alu_valid && alu_ready;
   assign pop       = !rst && nonempty && (forced || !alu_valid);
   assign push      = mem_valid && mem_ready;
   wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .din_i   ({mem_thread, mem_rd, mem_data}),
      .head_o  (head),
      .count_o (count),
      .vld_o   (fvld),
      .thr_o   (fthr)
   );
   always_comb begin
      out_d    = out_q;
      we_d     = 1'b0;
      pwe_d    = 1'b0;
      pin_d    = pin_q;
      starve_d = (pop || !nonempty) ? '0 : (alu_go && starve_q != SW'(STARVE_LIMIT)) ? starve_q + SW'(1) : starve_q;
      if (alu_go) begin
         out_d = {alu_thread, alu_rd, alu_data};
         we_d  = alu_wr_en && alu_rd >= reg_idx_t'(FIRST_GPR);
         pwe_d = alu_pred_en;
         pin_d = alu_pred;
      end else if (pop) begin
         out_d = head;
         we_d  = head.rd >= reg_idx_t'(FIRST_GPR);
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         out_q    <= '0;
         we_q     <= 1'b0;
         pwe_q    <= 1'b0;
         pin_q    <= 1'b0;
         starve_q <= '0;
      end else begin
         out_q    <= out_d;
         we_q     <= we_d;
         pwe_q    <= pwe_d;
         pin_q    <= pin_d;
         starve_q <= starve_d;
      end
   end
   always_comb begin
      wb_pending = (we_q || pwe_q) ? 16'(1) << out_q.thread : '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
         if (fvld[i]) wb_pending = wb_pending | (16'(1) << fthr[i]);
   end
   assign write_thread       = out_q.thread;
   assign write_rd           = out_q.rd;
   assign write_data         = out_q.data;
   assign write_en           = we_q;
   assign predicate_write_en = pwe_q;
   assign predicate_in       = pin_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb_writeback_arbiter: encoding vectors plus scoreboarded multi-cycle
// sequences for starvation, FIFO fill and mid-operation reset.
module tb_writeback_arbiter;
   import gpu_pkg::*;
   logic clk = 1'b0, rst;
   logic alu_valid, alu_ready, alu_wr_en, alu_pred_en, alu_pred;
   logic [3:0] alu_thread, alu_rd, mem_thread, mem_rd, write_thread, write_rd;
   logic [17:0] alu_data, mem_data, write_data;
   logic mem_valid, mem_ready, write_en, predicate_write_en, predicate_in;
   logic [15:0] wb_pending;
   always #5 clk = ~clk;
   writeback_arbiter dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_thread(alu_thread),
      .alu_rd(alu_rd), .alu_data(alu_data), .alu_wr_en(alu_wr_en),
      .alu_pred_en(alu_pred_en), .alu_pred(alu_pred),
      .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_thread(mem_thread),
      .mem_rd(mem_rd), .mem_data(mem_data),
      .write_thread(write_thread), .write_rd(write_rd), .write_data(write_data),
      .write_en(write_en), .predicate_write_en(predicate_write_en),
      .predicate_in(predicate_in), .wb_pending(wb_pending)
   );
   typedef struct {logic [3:0] t, r; logic [17:0] d; logic we, pwe, pin;} wr_t;
   typedef struct {logic [3:0] t, r; logic [17:0] d;} ld_t;
   typedef struct {logic mem; logic [3:0] t, r; logic [17:0] d; logic wen, pe, p, x_we, x_pwe, x_pin;} vec_t;
   wr_t sb[$];
   ld_t mq[$];
   wr_t last;
   int starve;
   int total = 0, bad = 0;
   logic [7:0] ar_hist;
   vec_t tbl [7];
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask
   function automatic logic [15:0] model_pend();
      logic [15:0] p = '0;
      foreach (mq[i]) p[mq[i].t] = 1'b1;
      if (last.we || last.pwe) p[last.t] = 1'b1;
      return p;
   endfunction
   task automatic step(input logic r, av, input logic [3:0] at, ar, input logic [17:0] ad,
                       input logic awe, ape, ap, mv, input logic [3:0] mt, mr, input logic [17:0] md);
      int cnt;
      bit forced;
      wr_t e;
      ld_t h;
      @(negedge clk);
      rst = r; alu_valid = av; alu_thread = at; alu_rd = ar; alu_data = ad;
      alu_wr_en = awe; alu_pred_en = ape; alu_pred = ap;
      mem_valid = mv; mem_thread = mt; mem_rd = mr; mem_data = md;
      #1;
      cnt = mq.size();
      forced = cnt > 0 && (cnt >= 3 || starve == 3);
      chk("wb_pending", wb_pending, model_pend());
      if (r) begin
         chk("alu_ready_in_rst", alu_ready, 0);
         chk("mem_ready_in_rst", mem_ready, 0);
         mq.delete();
         starve = 0;
         e = '{default: '0};
      end else begin
         chk("alu_ready", alu_ready, !forced);
         chk("mem_ready", mem_ready, cnt != 4);
         ar_hist = {ar_hist[6:0], alu_ready};
         e = last; e.we = 0; e.pwe = 0;
         if (av && !forced) begin
            e.t = at; e.r = ar; e.d = ad; e.we = awe && ar > 3; e.pwe = ape; e.pin = ap;
            if (cnt > 0) starve = (starve == 3) ? 3 : starve + 1;
         end else if (cnt > 0) begin
            h = mq.pop_front();
            e.t = h.t; e.r = h.r; e.d = h.d; e.we = h.r > 3;
            starve = 0;
         end
         if (cnt == 0) starve = 0;
         if (mv && cnt != 4) mq.push_back(ld_t'{mt, mr, md});
      end
      sb.push_back(e);
      @(posedge clk); #1;
      e = sb.pop_front();
      last = e;
      chk("write_en", write_en, e.we);
      chk("predicate_write_en", predicate_write_en, e.pwe);
      chk("predicate_in", predicate_in, e.pin);
      chk("write_thread", write_thread, e.t);
      chk("write_rd", write_rd, e.r);
      chk("write_data", write_data, e.d);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   initial begin
      tbl[0] = '{0, 4'd5,  4'd7,  18'h0002A, 1, 0, 0, 1, 0, 0};
      tbl[1] = '{0, 4'd3,  4'd2,  18'h00015, 1, 1, 1, 0, 1, 1};
      tbl[2] = '{0, 4'd9,  4'd15, 18'h3FFFF, 0, 0, 0, 0, 0, 0};
      tbl[3] = '{0, 4'd15, 4'd4,  18'h00001, 1, 1, 0, 1, 1, 0};
      tbl[4] = '{1, 4'd2,  4'd4,  18'h3FFFF, 0, 0, 0, 1, 0, 0};
      tbl[5] = '{1, 4'd7,  4'd0,  18'h00005, 0, 0, 0, 0, 0, 0};
      tbl[6] = '{1, 4'd1,  4'd3,  18'h12345, 0, 0, 0, 0, 0, 0};
      rst = 1; alu_valid = 0; alu_thread = 0; alu_rd = 0; alu_data = 0;
      alu_wr_en = 0; alu_pred_en = 0; alu_pred = 0;
      mem_valid = 0; mem_thread = 0; mem_rd = 0; mem_data = 0;
      ar_hist = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_write_en", write_en, 0);
      chk("reset_pred_we", predicate_write_en, 0);
      chk("reset_write_data", write_data, 0);
      chk("reset_pending", wb_pending, 0);
      chk("reset_alu_ready", alu_ready, 0);
      chk("reset_mem_ready", mem_ready, 0);
      last = '{default: '0};
      starve = 0;
      idle(1);
      foreach (tbl[k]) begin
         if (!tbl[k].mem) begin
            step(0, 1, tbl[k].t, tbl[k].r, tbl[k].d, tbl[k].wen, tbl[k].pe, tbl[k].p, 0, 0, 0, 0);
         end else begin
            step(0, 0, 0, 0, 0, 0, 0, 0, 1, tbl[k].t, tbl[k].r, tbl[k].d);
            chk("tbl_no_bypass", write_en, 0);
            chk("tbl_pending_queued", wb_pending[tbl[k].t], 1);
            idle(1);
         end
         chk("tbl_write_en", write_en, tbl[k].x_we);
         chk("tbl_pred_we", predicate_write_en, tbl[k].x_pwe);
         if (tbl[k].x_pwe) chk("tbl_pred_in", predicate_in, tbl[k].x_pin);
         chk("tbl_data", write_data, tbl[k].d);
         chk("tbl_thread", write_thread, tbl[k].t);
      end
      idle(2);
      step(0, 1, 4'd1, 4'd5, 18'h100, 1, 0, 0, 1, 4'd6, 4'd8, 18'h0BEEF);
      for (int i = 1; i < 6; i++) step(0, 1, 4'd1, 4'd5, 18'(18'h100 + i), 1, 0, 0, 0, 0, 0, 0);
      chk("starve_ready_pattern", ar_hist[5:0], 6'b111101);
      idle(3);
      for (int i = 0; i < 8; i++)
         step(0, 1, 4'd3, 4'd9, 18'(18'h200 + i), 1, 0, 0, i < 4, 4'(8 + i), 4'(4 + i), 18'(18'h300 + i));
      idle(4);
      for (int i = 0; i < 3; i++)
         step(0, 1, 4'd4, 4'd6, 18'(18'h400 + i), 1, 0, 0, 1, 4'(10 + i), 4'd7, 18'(18'h500 + i));
      step(1, 1, 4'd4, 4'd6, 18'h4FF, 1, 0, 0, 1, 4'd13, 4'd7, 18'h5FF);
      chk("rst_flush_pending", wb_pending, 0);
      idle(5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
